// File: rtl/writeback_unit_pkg.sv
// Shared constants and types for the MIPS writeback stage (package mips_pkg).
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    typedef struct packed {
        logic              reg_write;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Valid/ready handshake between the multiply/divide unit and the writeback stage.
interface writeback_unit_if;
    import mips_pkg::*;

    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_dest;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    modport master (output mdu_valid, output mdu_dest, output mdu_data, input  mdu_ready);
    modport slave  (input  mdu_valid, input  mdu_dest, input  mdu_data, output mdu_ready);

endinterface

// File: rtl/writeback_unit_load_align.sv
// Combinational little-endian load lane selection and sign/zero extension.
module load_align
    import mips_pkg::*;
(
    input  logic [2:0]        load_type,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] result,
    output logic              misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw[7:0];
        case (offset)
            2'd1:    byte_lane = raw[15:8];
            2'd2:    byte_lane = raw[23:16];
            2'd3:    byte_lane = raw[31:24];
            default: byte_lane = raw[7:0];
        endcase
        half_lane = offset[1] ? raw[31:16] : raw[15:0];
    end

    // Unknown load codes fall through to the word path.
    always_comb begin
        result     = raw;
        misaligned = 1'b0;
        case (load_type)
            LT_LB:  result = {{24{byte_lane[7]}}, byte_lane};
            LT_LBU: result = {24'd0, byte_lane};
            LT_LH: begin
                result     = {{16{half_lane[15]}}, half_lane};
                misaligned = offset[0];
            end
            LT_LHU: begin
                result     = {16'd0, half_lane};
                misaligned = offset[0];
            end
            default: begin
                result     = raw;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB register and register-file write port shared with the MDU result buffer.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/LW suppress the write and raise misalign_exc.
module writeback_unit
    import mips_pkg::*;
#(
    parameter int unsigned MDU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              mem_to_reg,
    input  logic [2:0]        mem_load_type,
    input  logic              stall,
    input  logic              flush,
    writeback_unit_if.slave   mdu,
    output logic              hold_req,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_exc,
    output logic [DATA_W-1:0] misalign_addr
`endif
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MDU_MAX_WAIT);

    logic              wb_valid;
    wb_entry_t         wb_q;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_dest;
    logic [DATA_W-1:0] buf_data;
    logic [3:0]        wait_cnt;

    logic [DATA_W-1:0] aligned_data;
    logic              misaligned;
    logic              capture;
    logic              wb_req;
    logic              grant_mdu;
    logic              grant_wb;
    logic              load_fault;

    load_align u_load_align (
        .load_type  (mem_load_type),
        .offset     (mem_alu_result[1:0]),
        .raw        (mem_load_data),
        .result     (aligned_data),
        .misaligned (misaligned)
    );

    assign load_fault = mem_to_reg & misaligned;
    assign capture    = !flush & !stall & !hold_req;
    assign wb_req     = wb_valid & wb_q.reg_write & (wb_q.dest != REG_ZERO);
    assign hold_req   = buf_valid & (wait_cnt >= WAIT_LIMIT);
    assign grant_mdu  = hold_req | (!wb_req & buf_valid);
    assign grant_wb   = !hold_req & wb_req;
    assign mdu.mdu_ready = !buf_valid;

    // A forced hold freezes the WB entry so it can write once the MDU has drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_q     <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (capture) begin
            wb_valid     <= mem_valid;
            wb_q.dest    <= mem_dest;
            wb_q.data    <= mem_to_reg ? aligned_data : mem_alu_result;
`ifdef MISALIGN_TRAP_EN
            wb_q.reg_write <= mem_reg_write & !load_fault;
`else
            wb_q.reg_write <= mem_reg_write;
`endif
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_exc <= capture & mem_valid & load_fault;
            if (capture & mem_valid & load_fault) begin
                misalign_addr <= mem_alu_result;
            end
        end
    end
`else
    logic unused_load_fault;
    assign unused_load_fault = load_fault;
`endif

    // Offers to register 0 complete the handshake but never occupy the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_dest  <= REG_ZERO;
            buf_data  <= '0;
            wait_cnt  <= 4'd0;
        end else if (grant_mdu) begin
            buf_valid <= 1'b0;
            wait_cnt  <= 4'd0;
        end else if (!buf_valid) begin
            wait_cnt <= 4'd0;
            if (mdu.mdu_valid && (mdu.mdu_dest != REG_ZERO)) begin
                buf_valid <= 1'b1;
                buf_dest  <= mdu.mdu_dest;
                buf_data  <= mdu.mdu_data;
            end
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        reg_write     = 1'b0;
        write_address = REG_ZERO;
        write_data    = '0;
        if (grant_mdu) begin
            reg_write     = 1'b1;
            write_address = buf_dest;
            write_data    = buf_data;
        end else if (grant_wb) begin
            reg_write     = 1'b1;
            write_address = wb_q.dest;
            write_data    = wb_q.data;
        end
    end

    assign fwd_valid = reg_write & (write_address != REG_ZERO);
    assign fwd_dest  = write_address;
    assign fwd_data  = write_data;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized checks of writeback_unit against a queue-based reference model.
module tb_writeback_unit;

    localparam int unsigned MAX_WAIT = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_valid, mem_reg_write, mem_to_reg, stall, flush;
    logic [4:0]  mem_dest;
    logic [31:0] mem_alu_result, mem_load_data;
    logic [2:0]  mem_load_type;
    logic        hold_req, reg_write, fwd_valid;
    logic [4:0]  write_address, fwd_dest;
    logic [31:0] write_data, fwd_data;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_exc;
    logic [31:0] misalign_addr;
`endif

    writeback_unit_if mdu_bus ();

    writeback_unit #(.MDU_MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_to_reg(mem_to_reg), .mem_load_type(mem_load_type),
        .stall(stall), .flush(flush), .mdu(mdu_bus),
        .hold_req(hold_req), .reg_write(reg_write), .write_address(write_address),
        .write_data(write_data), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`ifdef MISALIGN_TRAP_EN
        , .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    // Reference model: pipeline entry, MDU buffer as a queue, loss counter.
    logic        m_valid, m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    wr_t         m_buf[$];
    int          m_wait;
    logic        m_exc;
    logic [31:0] m_exc_addr;

    function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] addr,
                                             input logic [31:0] raw);
        int          off;
        logic [31:0] b, h;
        off = int'(addr[1:0]);
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            3'd3:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2:    return h;
            default: return raw;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] lt, input logic [31:0] addr);
        if (lt == 3'd3 || lt == 3'd4) return 1'b0;
        if (lt == 3'd1 || lt == 3'd2) return addr[0];
        return addr[1:0] != 2'b00;
    endfunction

    function automatic bit exp_hold();
        return (m_buf.size() != 0) && (m_wait >= int'(MAX_WAIT));
    endfunction

    // Returns 1 when a write is expected this cycle; from_mdu says who owns it.
    function automatic bit exp_write(output wr_t w, output bit from_mdu);
        bit pipe_req;
        pipe_req = m_valid && m_we && (m_dest != 5'd0);
        w.dest = 5'd0;
        w.data = 32'd0;
        from_mdu = 1'b0;
        if (exp_hold() || (!pipe_req && m_buf.size() != 0)) begin
            w = m_buf[0];
            from_mdu = 1'b1;
            return 1'b1;
        end
        if (pipe_req) begin
            w.dest = m_dest;
            w.data = m_data;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_dest = 5'd0; m_data = 32'd0;
        m_buf.delete();
        m_wait = 0;
        m_exc = 1'b0; m_exc_addr = 32'd0;
    endtask

    task automatic model_update();
        wr_t w;
        bit  from_mdu, wr, held, was_empty, fault, take;
        wr = exp_write(w, from_mdu);
        held = exp_hold();
        was_empty = (m_buf.size() == 0);
        if (wr && from_mdu) begin
            m_buf.delete();
            m_wait = 0;
        end else if (was_empty) begin
            m_wait = 0;
            if (mdu_bus.mdu_valid && mdu_bus.mdu_dest != 5'd0)
                m_buf.push_back('{dest: mdu_bus.mdu_dest, data: mdu_bus.mdu_data});
        end else if (m_wait < 15) begin
            m_wait++;
        end
        take = !flush && !stall && !held;
        fault = mem_to_reg && ref_misaligned(mem_load_type, mem_alu_result);
        if (TRAP) begin
            m_exc = take && mem_valid && fault;
            if (m_exc) m_exc_addr = mem_alu_result;
        end
        if (flush) begin
            m_valid = 1'b0;
        end else if (take) begin
            m_valid = mem_valid;
            m_we    = mem_reg_write && !(TRAP && fault);
            m_dest  = mem_dest;
            m_data  = mem_to_reg ? ref_load(mem_load_type, mem_alu_result, mem_load_data)
                                 : mem_alu_result;
        end
    endtask

    task automatic check_output();
        wr_t w;
        bit  from_mdu, wr;
        wr = exp_write(w, from_mdu);
        check("reg_write", 32'(reg_write), 32'(wr));
        check("write_address", 32'(write_address), 32'(w.dest));
        check("write_data", write_data, w.data);
        check("hold_req", 32'(hold_req), 32'(exp_hold()));
        check("mdu_ready", 32'(mdu_bus.mdu_ready), 32'(m_buf.size() == 0));
        check("fwd_valid", 32'(fwd_valid), 32'(wr && w.dest != 5'd0));
        check("fwd_dest", 32'(fwd_dest), 32'(w.dest));
        check("fwd_data", fwd_data, w.data);
`ifdef MISALIGN_TRAP_EN
        check("misalign_exc", 32'(misalign_exc), 32'(m_exc));
        check("misalign_addr", misalign_addr, m_exc_addr);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_update();
        @(negedge clk);
        check_output();
    endtask

    task automatic apply_stimulus(input logic v, input logic we, input logic [4:0] dest,
                                  input logic to_reg, input logic [2:0] lt,
                                  input logic [31:0] alu, input logic [31:0] raw);
        mem_valid = v; mem_reg_write = we; mem_dest = dest; mem_to_reg = to_reg;
        mem_load_type = lt; mem_alu_result = alu; mem_load_data = raw;
    endtask

    task automatic offer_mdu(input logic v, input logic [4:0] dest, input logic [31:0] data);
        mdu_bus.mdu_valid = v; mdu_bus.mdu_dest = dest; mdu_bus.mdu_data = data;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        stall = 1'b0; flush = 1'b0;
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        offer_mdu(1'b0, 5'd0, 32'd0);
        model_reset();
        #3;
        check("reset_reg_write", 32'(reg_write), 32'd0);
        check("reset_write_data", write_data, 32'd0);
        check("reset_mdu_ready", 32'(mdu_bus.mdu_ready), 32'd1);
        check("reset_hold_req", 32'(hold_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load alignment
        apply_stimulus(1'b1, 1'b1, 5'd3, 1'b1, 3'd3, 32'h101, 32'h80FF_7F01);
        cycle();
        check("lb_off1", write_data, 32'h0000_007F);
        apply_stimulus(1'b1, 1'b1, 5'd3, 1'b1, 3'd3, 32'h103, 32'h80FF_7F01);
        cycle();
        check("lb_off3", write_data, 32'hFFFF_FF80);
        apply_stimulus(1'b1, 1'b1, 5'd3, 1'b1, 3'd4, 32'h102, 32'h80FF_7F01);
        cycle();
        check("lbu_off2", write_data, 32'h0000_00FF);
        apply_stimulus(1'b1, 1'b1, 5'd3, 1'b1, 3'd1, 32'h102, 32'h80FF_7F01);
        cycle();
        check("lh_off2", write_data, 32'hFFFF_80FF);

        // Register zero is never written
        apply_stimulus(1'b1, 1'b1, 5'd0, 1'b0, 3'd0, 32'h1234, 32'd0);
        cycle();
        check("r0_alu_no_write", 32'(reg_write), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        offer_mdu(1'b1, 5'd0, 32'h55);
        cycle();
        check("r0_mdu_ready", 32'(mdu_bus.mdu_ready), 32'd1);
        offer_mdu(1'b0, 5'd0, 32'd0);
        cycle();
        check("r0_mdu_no_write", 32'(reg_write), 32'd0);

        // MDU result with an idle pipeline
        offer_mdu(1'b1, 5'd9, 32'hDEAD_BEEF);
        cycle();
        check("mdu_write_addr", 32'(write_address), 32'd9);
        check("mdu_write_data", write_data, 32'hDEAD_BEEF);
        check("mdu_busy", 32'(mdu_bus.mdu_ready), 32'd0);
        offer_mdu(1'b0, 5'd0, 32'd0);
        cycle();
        check("mdu_ready_again", 32'(mdu_bus.mdu_ready), 32'd1);

        // Starved MDU buffer forces a hold
        for (int k = 0; k <= 6; k++) begin
            apply_stimulus(1'b1, 1'b1, 5'(10 + k), 1'b0, 3'd0, $urandom, 32'd0);
            if (k == 0) offer_mdu(1'b1, 5'd7, 32'h77);
            else offer_mdu(1'b0, 5'd0, 32'd0);
            cycle();
            if (k == 4) begin
                check("hold_5th_cycle", 32'(hold_req), 32'd1);
                check("hold_mdu_addr", 32'(write_address), 32'd7);
                check("hold_mdu_data", write_data, 32'h77);
            end
            if (k == 5) begin
                check("held_wb_addr", 32'(write_address), 32'd14);
                check("hold_released", 32'(hold_req), 32'd0);
            end
        end
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        cycle();
        cycle();

        // Asynchronous reset with the buffer full
        apply_stimulus(1'b1, 1'b1, 5'd20, 1'b0, 3'd0, 32'h2020, 32'd0);
        offer_mdu(1'b1, 5'd21, 32'hAAAA_5555);
        cycle();
        offer_mdu(1'b0, 5'd0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_reg_write", 32'(reg_write), 32'd0);
        check("async_rst_write_data", write_data, 32'd0);
        check("async_rst_write_addr", 32'(write_address), 32'd0);
        check("async_rst_mdu_ready", 32'(mdu_bus.mdu_ready), 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_buffer_dropped", 32'(reg_write), 32'd0);

        // Flush beats stall
        apply_stimulus(1'b1, 1'b1, 5'd6, 1'b0, 3'd0, 32'h66, 32'd0);
        cycle();
        apply_stimulus(1'b1, 1'b1, 5'd8, 1'b0, 3'd0, 32'h88, 32'd0);
        flush = 1'b1; stall = 1'b1;
        cycle();
        check("flush_stall_bubble", 32'(reg_write), 32'd0);
        flush = 1'b0; stall = 1'b0;
`ifdef MISALIGN_TRAP_EN
        apply_stimulus(1'b1, 1'b1, 5'd5, 1'b1, 3'd0, 32'h0000_1002, 32'h1234_5678);
        cycle();
        check("trap_exc", 32'(misalign_exc), 32'd1);
        check("trap_addr", misalign_addr, 32'h0000_1002);
        check("trap_no_write", 32'(reg_write), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        cycle();
        check("trap_pulse_end", 32'(misalign_exc), 32'd0);
`endif
        apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom),
                           1'($urandom), 3'($urandom), $urandom, $urandom);
            stall = ($urandom % 8) == 0;
            flush = ($urandom % 16) == 0;
            offer_mdu(($urandom % 3) == 0, 5'($urandom), $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- MEM/WB pipeline register plus writeback logic for the MIPS core.
- Drives the write side of the register file: write enable, 5-bit address and 32-bit data.
- Aligns and extends load data.
- Arbitrates the single write port between the pipeline and the multi-cycle multiply/divide unit (MDU) through a one-entry buffer with a valid/ready handshake.
- Provides a forwarding tap of the value currently being written.

Parameters:
MDU_MAX_WAIT, 4, cycles a buffered MDU result may lose arbitration before the block forces a pipeline hold (range 1..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes a GPR
mem_dest  in  5  destination register
mem_alu_result  in  32  ALU result / byte address for loads
mem_load_data  in  32  raw word read from data memory
mem_to_reg  in  1  1 = load, 0 = ALU result
mem_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes treated as LW
stall  in  1  hold the MEM/WB register
flush  in  1  load a bubble into the MEM/WB register
mdu_valid  in  1  MDU offers a result
mdu_dest  in  5  MDU destination register
mdu_data  in  32  MDU result
mdu_ready  out  1  buffer empty; offer accepted this cycle
hold_req  out  1  forced pipeline hold, so the MDU can drain
reg_write  out  1  register file write enable
write_address  out  5  register file write address
write_data  out  32  register file write data
fwd_valid  out  1  the write this cycle targets a nonzero register
fwd_dest  out  5  equals write_address
fwd_data  out  32  equals write_data

Behaviour:
- Reset (rst low, async):
  - MEM/WB valid = 0, MDU buffer empty, wait counter = 0.
  - Outputs: reg_write = 0, write_address = 0, write_data = 0, hold_req = 0, fwd_valid = 0, mdu_ready = 1.
- MEM/WB register, updated per rising edge:
  - flush has priority: valid <= 0.
  - Otherwise, if stall or hold_req: hold the current contents.
  - Otherwise: capture the mem_* inputs. Load alignment is applied at capture, so only the final 32-bit result is stored.
- Load alignment uses little-endian byte offset off = mem_alu_result[1:0]:
  - LB / LBU: byte off, sign- or zero-extended.
  - LH / LHU: halfword selected by off[1], sign- or zero-extended.
  - LW: whole word.
  - A misaligned halfword (off[0] = 1) or word (off != 0) uses the aligned lane, ignoring the low bits (see optional feature).
- MDU buffer:
  - mdu_ready = !buf_valid, derived combinationally from the registered buf_valid.
  - Transfer occurs when mdu_valid & mdu_ready; the buffer fills on that edge.
  - An entry with mdu_dest = 0 is accepted and discarded: the buffer stays empty.
- Write-port arbitration, combinational from registered state only:
  - wb_req = wb_valid & wb_reg_write & (wb_dest != 0).
  - If hold_req: grant the MDU buffer.
  - Else if wb_req: grant the pipeline.
  - Else if buf_valid: grant the MDU buffer.
  - Otherwise reg_write = 0, and write_address / write_data = 0.
- Buffer release:
  - The buffer empties on the edge where it is granted.
  - mdu_ready rises the following cycle; there is no same-cycle refill.
- Wait counter:
  - Increments each cycle buf_valid & !grant_mdu; clears when the buffer empties.
  - hold_req = buf_valid & (count >= MDU_MAX_WAIT).
  - hold_req is asserted for exactly the cycle in which the MDU is granted. The WB entry then retains its state and writes in the next cycle.
- Register 0 is never written: reg_write is never asserted with write_address = 0.
- Forwarding outputs mirror the granted write in the same cycle.
- Ordering of MDU vs. pipeline writes to the same register is owned by the hazard unit, not by this block.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A misaligned LH/LHU/LW captured into MEM/WB clears wb_reg_write.
  - Adds output misalign_exc (1 bit, registered, reset 0), pulsed for one cycle when the entry is captured.
  - Adds output misalign_addr (32 bits), holding the faulting address.
- Undefined: those ports do not exist, and misaligned loads silently use the aligned lane.

Decomposition:
- Package mips_pkg:
  - load-type constants: LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU.
  - REG_ZERO = 5'd0; widths DATA_W = 32, ADDR_W = 5.
- Sub-module load_align: purely combinational (type, offset, raw word -> 32-bit result, misaligned flag), instantiated once.

Test Plan:
1. mem_load_data = 32'h80FF_7F01, LB with off = 1 -> write_data 32'h0000_007F. LB with off = 3 -> 32'hFFFF_FF80. LBU with off = 2 -> 32'h0000_00FF. LH with off = 2 -> 32'hFFFF_80FF.
2. ALU op with dest = 0 and reg_write = 1 -> reg_write stays 0. MDU offer with dest = 0 -> accepted, buffer stays empty, mdu_ready remains 1.
3. MDU result (dest 9, 32'hDEAD_BEEF) with an idle pipeline -> accepted at edge N, written at cycle N+1, mdu_ready high again at N+2.
4. Back-to-back pipeline writes while the MDU buffer is full, MDU_MAX_WAIT = 4 -> hold_req high in the 5th cycle. The MDU writes that cycle, the held WB entry writes the next cycle, and no write is lost.
5. Assert rst low mid-stream with the buffer full -> outputs zero immediately, mdu_ready = 1, and the buffered value is never written.
6. flush and stall both high -> bubble inserted and no write next cycle. With MISALIGN_TRAP_EN, LW at address 0x1002 -> misaligned_exc pulses, misalign_addr = 32'h0000_1002, no register write.
